// File: rtl/float_to_spike.sv
// Threshold stage: compares an IEEE-754 single operand against a fixed threshold and
// returns a 1-bit spike over STB/BUSY handshakes, one operand in flight at a time.
module float_to_spike #(
  parameter logic [31:0] THRESHOLD = 32'h3F000000,
  parameter bit          INCLUSIVE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_x,
  input  logic        thr_input_STB,
  output logic        thr_BUSY,
  output logic        output_tp,
  output logic        thr_output_STB,
  input  logic        output_module_BUSY
);

  typedef enum logic [2:0] {StIdle, StUnpack, StCompare, StPut, StFinish} state_e;

  localparam logic        TSign = THRESHOLD[31];
  localparam logic [30:0] TMag  = THRESHOLD[30:0];
  localparam logic        TNan  = (THRESHOLD[30:23] == 8'hFF) && (THRESHOLD[22:0] != 23'd0);
  localparam logic        TZero = (THRESHOLD[30:0] == 31'd0);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        stb_q, stb_d;
  logic        tp_q, tp_d;
  logic [31:0] x_q, x_d;
  logic        x_sign_q, x_sign_d;
  logic [30:0] x_mag_q, x_mag_d;
  logic        x_nan_q, x_nan_d;
  logic        x_zero_q, x_zero_d;
  logic        result_q, result_d;
  logic        cmp_gt, cmp_eq, cmp_result;

  // Sign-magnitude ordering; {exp,mant} compares as an unsigned integer for
  // normals, denormals and infinities alike.
  always_comb begin
    cmp_gt = 1'b0;
    cmp_eq = 1'b0;
    if (x_zero_q && TZero) begin
      cmp_eq = 1'b1;
    end else if (x_sign_q != TSign) begin
      cmp_gt = ~x_sign_q;
    end else if (!x_sign_q) begin
      cmp_gt = x_mag_q > TMag;
      cmp_eq = x_mag_q == TMag;
    end else begin
      cmp_gt = x_mag_q < TMag;
      cmp_eq = x_mag_q == TMag;
    end
    cmp_result = (x_nan_q || TNan) ? 1'b0 : (cmp_gt || (INCLUSIVE && cmp_eq));
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    stb_d    = stb_q;
    tp_d     = tp_q;
    x_d      = x_q;
    x_sign_d = x_sign_q;
    x_mag_d  = x_mag_q;
    x_nan_d  = x_nan_q;
    x_zero_d = x_zero_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        // Registered busy gates acceptance, so the first idle cycle never accepts.
        if (thr_input_STB && !busy_q) begin
          x_d     = input_x;
          busy_d  = 1'b1;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        x_sign_d = x_q[31];
        x_mag_d  = x_q[30:0];
        x_nan_d  = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
        x_zero_d = (x_q[30:0] == 31'd0);
        state_d  = StCompare;
      end
      StCompare: begin
        result_d = cmp_result;
        state_d  = StPut;
      end
      StPut: begin
        tp_d    = result_q;
        stb_d   = 1'b1;
        state_d = StFinish;
      end
      StFinish: begin
        if (stb_q && !output_module_BUSY) begin
          stb_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      tp_q    <= tp_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q      <= x_d;
    x_sign_q <= x_sign_d;
    x_mag_q  <= x_mag_d;
    x_nan_q  <= x_nan_d;
    x_zero_q <= x_zero_d;
    result_q <= result_d;
  end

  assign thr_BUSY       = busy_q;
  assign output_tp      = tp_q;
  assign thr_output_STB = stb_q;

endmodule

// File: tb/tb_float_to_spike.sv
// Bench for float_to_spike: four instances (T=0.5/0.0, inclusive/exclusive) share stimulus;
// bit i of each expected vector belongs to instance i.
module tb_float_to_spike;

  localparam logic [31:0] F_ONE   = 32'h3F800000;
  localparam logic [31:0] F_QTR   = 32'h3E800000;
  localparam logic [31:0] F_HALF  = 32'h3F000000;
  localparam logic [31:0] F_MONE  = 32'hBF800000;
  localparam logic [31:0] F_NAN   = 32'h7FC00000;
  localparam logic [31:0] F_INF   = 32'h7F800000;
  localparam logic [31:0] F_DEN   = 32'h00000001;
  localparam logic [31:0] F_NZERO = 32'h80000000;
  localparam logic [31:0] F_PZERO = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_x = 32'd0;
  logic        in_stb = 1'b0;
  logic        obusy = 1'b0;
  logic [3:0]  busy, tp, ostb;

  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  float_to_spike #(.THRESHOLD(32'h3F000000), .INCLUSIVE(1'b1)) u_half_inc (
    .clk(clk), .rst(rst), .input_x(input_x), .thr_input_STB(in_stb), .thr_BUSY(busy[0]),
    .output_tp(tp[0]), .thr_output_STB(ostb[0]), .output_module_BUSY(obusy));
  float_to_spike #(.THRESHOLD(32'h3F000000), .INCLUSIVE(1'b0)) u_half_exc (
    .clk(clk), .rst(rst), .input_x(input_x), .thr_input_STB(in_stb), .thr_BUSY(busy[1]),
    .output_tp(tp[1]), .thr_output_STB(ostb[1]), .output_module_BUSY(obusy));
  float_to_spike #(.THRESHOLD(32'h00000000), .INCLUSIVE(1'b1)) u_zero_inc (
    .clk(clk), .rst(rst), .input_x(input_x), .thr_input_STB(in_stb), .thr_BUSY(busy[2]),
    .output_tp(tp[2]), .thr_output_STB(ostb[2]), .output_module_BUSY(obusy));
  float_to_spike #(.THRESHOLD(32'h00000000), .INCLUSIVE(1'b0)) u_zero_exc (
    .clk(clk), .rst(rst), .input_x(input_x), .thr_input_STB(in_stb), .thr_BUSY(busy[3]),
    .output_tp(tp[3]), .thr_output_STB(ostb[3]), .output_module_BUSY(obusy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the acceptance edge.
  task automatic send(input logic [31:0] x, input logic [3:0] e, input bit push);
    int n = 0;
    while (busy[0] !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'h0);
    input_x = x;
    in_stb  = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 in_stb = 1'b0;
  endtask

  // Waits for the output strobe, checks latency and the scoreboard head; ends at a negedge.
  task automatic collect(input string tag);
    int lat = 0;
    logic [3:0] e;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (ostb[0] !== 1'b1 && lat < 10);
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_stb"}, 32'(ostb), 32'hF);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    chk(tag, 32'(tp), 32'(e));
    if (!obusy) begin
      @(negedge clk);
      chk({tag, "_stb_drop"}, 32'(ostb), 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] seen;
    logic [31:0] vals[4];
    logic [3:0]  exps[4];
    logic [3:0]  e;
    int idx, nres, last;

    repeat (3) @(negedge clk);
    chk("reset_state", {20'd0, busy, ostb, tp}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    send(F_ONE,   4'b1111, 1'b1); collect("one");
    send(F_QTR,   4'b1100, 1'b1); collect("quarter");
    send(F_HALF,  4'b1101, 1'b1); collect("equal_t");
    send(F_MONE,  4'b0000, 1'b1); collect("minus_one");
    send(F_NAN,   4'b0000, 1'b1); collect("nan");
    send(F_INF,   4'b1111, 1'b1); collect("plus_inf");
    send(F_DEN,   4'b1100, 1'b1); collect("min_denorm");
    send(F_NZERO, 4'b0100, 1'b1); collect("minus_zero");
    send(F_PZERO, 4'b0100, 1'b1); collect("plus_zero");

    // Backpressure: result held while downstream is busy; a stray input is dropped.
    obusy = 1'b1;
    send(F_QTR, 4'b1100, 1'b1);
    collect("bp_result");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_stb  = (i == 1);
      input_x = F_ONE;
      @(negedge clk);
      chk("bp_hold", {20'd0, ostb, tp, busy}, {20'd0, 4'hF, 4'b1100, 4'hF});
    end
    in_stb = 1'b0;
    obusy  = 1'b0;
    @(negedge clk);
    chk("bp_release", 32'(ostb), 32'h0);
    seen = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= ostb;
    end
    chk("bp_single_transfer", 32'(seen), 32'h0);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while in COMPARE, after a prior result of 1.
    send(F_ONE, 4'b1111, 1'b1); collect("pre_reset");
    send(F_ONE, 4'b1111, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midop_busy", 32'(busy), 32'hF);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midop_reset", {20'd0, busy, ostb, tp}, 32'h0);
    seen = 4'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= ostb;
    end
    chk("midop_no_strobe", 32'(seen), 32'h0);
    send(F_QTR, 4'b1100, 1'b1); collect("post_reset_qtr");
    send(F_ONE, 4'b1111, 1'b1); collect("post_reset_one");

    // Back-to-back with strobe held high.
    vals = '{F_ONE, F_QTR, F_ONE, F_QTR};
    exps = '{4'b1111, 4'b1100, 4'b1111, 4'b1100};
    idx = 0; nres = 0; last = 0;
    in_stb = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (ostb[0] === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
        chk("b2b_result", 32'(tp), 32'(e));
        if (nres > 0) chk("b2b_spacing", 32'(cyc - last), 32'd6);
        last = cyc;
        nres++;
      end
      if (busy[0] === 1'b0 && idx < 4) begin
        input_x = vals[idx];
        exp_q.push_back(exps[idx]);
        idx++;
      end else if (idx == 4 && busy[0] === 1'b1) begin
        in_stb = 1'b0;
      end
      @(negedge clk);
    end
    in_stb = 1'b0;
    chk("b2b_count", 32'(nres), 32'd4);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
